// File: rtl/chroni_bitmap_expander_if.sv
// Chroni pixel-write request channel (renderer -> expander) and the
// line-buffer RAM write port (expander -> line buffer).
interface chroni_bitmap_expander_if #(
  parameter int ADDR_WIDTH = 11
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [7:0]            wr_data;
  logic [7:0]            wr_bitmap_on;
  logic [7:0]            wr_bitmap_off;
  logic [3:0]            wr_bitmap_bits;
  logic                  wr_busy;

  modport master (
    output wr_en, wr_addr, wr_data, wr_bitmap_on, wr_bitmap_off, wr_bitmap_bits,
    input  wr_busy
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, wr_bitmap_on, wr_bitmap_off, wr_bitmap_bits,
    output wr_busy
  );
endinterface

interface chroni_linebuf_wr_if #(
  parameter int ADDR_WIDTH = 11
);
  logic                  buf_wr_en;
  logic [ADDR_WIDTH-1:0] buf_wr_addr;
  logic [7:0]            buf_wr_data;

  modport master (output buf_wr_en, buf_wr_addr, buf_wr_data);
  modport slave  (input  buf_wr_en, buf_wr_addr, buf_wr_data);
endinterface

// File: rtl/chroni_bitmap_expander.sv
// Expands one font/bitmap byte MSB-first into 1-8 palette-index pixels (or
// passes a direct pixel) and writes one pixel per cycle into the line buffer.
module chroni_bitmap_expander #(
  parameter int BUFFER_SIZE = 1280,
  parameter int ADDR_WIDTH  = 11
) (
  input  logic                       sys_clk,
  input  logic                       reset_n,
  input  logic                       flush,
  chroni_bitmap_expander_if.slave    wr,
  chroni_linebuf_wr_if.master        lb
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                r_state, w_state_nxt;
  logic [7:0]            r_bits,  w_bits_nxt;
  logic [7:0]            r_on,    w_on_nxt;
  logic [7:0]            r_off,   w_off_nxt;
  logic [2:0]            r_cnt,   w_cnt_nxt;
  logic                  r_busy,  w_busy_nxt;
  logic                  r_en,    w_en_nxt;
  logic [ADDR_WIDTH-1:0] r_addr,  w_addr_nxt;
  logic [7:0]            r_data,  w_data_nxt;

  logic                  w_accept;
  logic [3:0]            w_in_n;
  logic [ADDR_WIDTH-1:0] w_in_addr;
  logic [ADDR_WIDTH-1:0] w_addr_inc;

  assign w_accept   = wr.wr_en & ~r_busy & ~flush;
  assign w_in_n     = (wr.wr_bitmap_bits == 4'd0) ? 4'd1 :
                      (wr.wr_bitmap_bits > 4'd8)  ? 4'd8 : wr.wr_bitmap_bits;
  assign w_in_addr  = ADDR_WIDTH'(int'(wr.wr_addr) % BUFFER_SIZE);
  assign w_addr_inc = (r_addr == ADDR_WIDTH'(BUFFER_SIZE - 1)) ? '0
                                                               : r_addr + ADDR_WIDTH'(1);

  // The first pixel is produced on the acceptance edge itself, so r_cnt
  // counts pixels still to come after the one currently on the outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_bits_nxt  = r_bits;
    w_on_nxt    = r_on;
    w_off_nxt   = r_off;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = 1'b0;
    w_en_nxt    = 1'b0;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;

    if (flush) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else if (r_state == EMIT && r_cnt != 3'd0) begin
      w_en_nxt   = 1'b1;
      w_addr_nxt = w_addr_inc;
      w_data_nxt = r_bits[7] ? r_on : r_off;
      w_bits_nxt = {r_bits[6:0], 1'b0};
      w_cnt_nxt  = r_cnt - 3'd1;
      w_busy_nxt = (r_cnt != 3'd1);
    end else if (w_accept) begin
      w_state_nxt = EMIT;
      w_en_nxt    = 1'b1;
      w_addr_nxt  = w_in_addr;
      w_data_nxt  = (wr.wr_bitmap_bits == 4'd0) ? wr.wr_data :
                    (wr.wr_data[7] ? wr.wr_bitmap_on : wr.wr_bitmap_off);
      w_bits_nxt  = {wr.wr_data[6:0], 1'b0};
      w_on_nxt    = wr.wr_bitmap_on;
      w_off_nxt   = wr.wr_bitmap_off;
      w_cnt_nxt   = 3'(w_in_n - 4'd1);
      w_busy_nxt  = (w_in_n != 4'd1);
    end else begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_bits  <= '0;
      r_on    <= '0;
      r_off   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_en    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_bits  <= w_bits_nxt;
      r_on    <= w_on_nxt;
      r_off   <= w_off_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_en    <= w_en_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
    end
  end

  assign wr.wr_busy     = r_busy;
  assign lb.buf_wr_en   = r_en;
  assign lb.buf_wr_addr = r_addr;
  assign lb.buf_wr_data = r_data;

endmodule

// File: tb/tb_chroni_bitmap_expander.sv
// Bench for chroni_bitmap_expander: directed scenarios plus random traffic,
// checked each cycle against a queue-of-pending-pixels reference model.
module tb_chroni_bitmap_expander;
  localparam int AW = 11;
  localparam int BS = 1280;

  logic sys_clk = 1'b0;
  logic reset_n = 1'b0;
  logic flush   = 1'b0;

  chroni_bitmap_expander_if #(.ADDR_WIDTH(AW)) u_wr ();
  chroni_linebuf_wr_if      #(.ADDR_WIDTH(AW)) u_lb ();

  chroni_bitmap_expander #(.BUFFER_SIZE(BS), .ADDR_WIDTH(AW)) dut (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .flush   (flush),
    .wr      (u_wr),
    .lb      (u_lb)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } pix_t;

  pix_t mq[$];   // mq[0] is the pixel on the outputs this cycle
  pix_t last;
  int   ntests = 0;
  int   nfail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  function automatic void model_load(input logic [AW-1:0] addr, input logic [7:0] data,
                                     input logic [7:0] on, input logic [7:0] off,
                                     input logic [3:0] bits);
    int n;
    int base;
    pix_t p;
    n    = (bits == 0) ? 1 : ((bits > 8) ? 8 : int'(bits));
    base = int'(addr) % BS;
    for (int i = 0; i < n; i++) begin
      p.a = AW'((base + i) % BS);
      if (bits == 0) p.d = data;
      else           p.d = data[7-i] ? on : off;
      mq.push_back(p);
    end
  endfunction

  function automatic void model_edge();
    logic m_busy;
    logic accept;
    m_busy = (mq.size() > 1);
    accept = u_wr.wr_en && !m_busy && !flush;
    if (flush) begin
      mq.delete();
    end else begin
      if (mq.size() > 0) void'(mq.pop_front());
      if (accept) model_load(u_wr.wr_addr, u_wr.wr_data, u_wr.wr_bitmap_on,
                             u_wr.wr_bitmap_off, u_wr.wr_bitmap_bits);
    end
    if (mq.size() > 0) last = mq[0];
  endfunction

  task automatic check_outputs();
    chk("buf_wr_en",   32'(u_lb.buf_wr_en),   32'(mq.size() > 0));
    chk("wr_busy",     32'(u_wr.wr_busy),     32'(mq.size() > 1));
    chk("buf_wr_addr", 32'(u_lb.buf_wr_addr), 32'(last.a));
    chk("buf_wr_data", 32'(u_lb.buf_wr_data), 32'(last.d));
  endtask

  task automatic cyc();
    @(posedge sys_clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic set_req(input logic [AW-1:0] addr, input logic [7:0] data,
                         input logic [7:0] on, input logic [7:0] off, input logic [3:0] bits);
    u_wr.wr_en          = 1'b1;
    u_wr.wr_addr        = addr;
    u_wr.wr_data        = data;
    u_wr.wr_bitmap_on   = on;
    u_wr.wr_bitmap_off  = off;
    u_wr.wr_bitmap_bits = bits;
  endtask

  task automatic req(input logic [AW-1:0] addr, input logic [7:0] data,
                     input logic [7:0] on, input logic [7:0] off, input logic [3:0] bits);
    set_req(addr, data, on, off, bits);
    cyc();
    u_wr.wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic pulse_reset();
    #2 reset_n = 1'b0;
    #1;
    mq.delete();
    last = '0;
    check_outputs();
    @(negedge sys_clk);
    reset_n = 1'b1;
  endtask

  initial begin
    last = '0;
    set_req('0, '0, '0, '0, '0);
    u_wr.wr_en = 1'b0;

    // Reset state
    #12;
    check_outputs();
    @(negedge sys_clk);
    reset_n = 1'b1;
    idle(2);

    // Expand basic followed by a back-to-back request in the final pixel cycle
    req(11'd16, 8'hA5, 8'h0F, 8'h00, 4'd8);
    chk("first_addr", 32'(u_lb.buf_wr_addr), 32'd16);
    chk("first_data", 32'(u_lb.buf_wr_data), 32'h0F);
    idle(7);
    chk("last_pixel_busy", 32'(u_wr.wr_busy), 32'd0);
    req(11'd24, 8'hFF, 8'h0F, 8'h00, 4'd8);
    idle(9);
    chk("hold_addr", 32'(u_lb.buf_wr_addr), 32'd31);

    // Partial count and clamp, plus on == off
    req(11'd100, 8'hC0 | 8'($urandom_range(0, 31)), 8'h11, 8'h22, 4'd3);
    idle(4);
    req(11'd200, 8'($urandom), 8'h33, 8'h44, 4'd12);
    idle(9);
    req(11'd300, 8'h5A, 8'h77, 8'h77, 4'd5);
    idle(6);

    // Direct write at the top address, then expansion wrapping through zero
    req(11'd1279, 8'h42, 8'h01, 8'h02, 4'd0);
    chk("direct_busy", 32'(u_wr.wr_busy), 32'd0);
    idle(2);
    req(11'd1278, 8'($urandom), 8'h0A, 8'h0B, 4'd4);
    idle(5);
    req(11'd2000, 8'h81, 8'h0C, 8'h0D, 4'd2);
    idle(3);

    // Flush on the third pixel cycle together with a new request
    req(11'd40, 8'hF0, 8'h09, 8'h06, 4'd8);
    idle(2);
    flush = 1'b1;
    set_req(11'd60, 8'hFF, 8'h01, 8'h01, 4'd8);
    cyc();
    flush = 1'b0;
    u_wr.wr_en = 1'b0;
    chk("flush_en", 32'(u_lb.buf_wr_en), 32'd0);
    idle(3);

    // Asynchronous reset mid-expansion, then a normal request
    req(11'd500, 8'h3C, 8'hAA, 8'h55, 4'd8);
    idle(3);
    pulse_reset();
    idle(1);
    req(11'd8, 8'h96, 8'hE0, 8'h0E, 4'd6);
    idle(7);

    // Requests while busy must be ignored
    req(11'd700, 8'hCC, 8'h21, 8'h12, 4'd8);
    idle(2);
    set_req(11'd900, 8'hFF, 8'h99, 8'h99, 4'd8);
    cyc();
    cyc();
    u_wr.wr_en = 1'b0;
    idle(6);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      set_req(AW'($urandom_range(0, 2047)), 8'($urandom), 8'($urandom),
              8'($urandom), 4'($urandom_range(0, 15)));
      u_wr.wr_en = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 24) == 0);
      cyc();
    end
    flush = 1'b0;
    u_wr.wr_en = 1'b0;
    idle(10);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
